// File: rtl/id_stage.sv
// RV32I decode stage feeding the ID/EX register, with load-use stall and branch flush.
// Optional RV32M decoding is enabled by defining RV32M_DECODE_EN.
module id_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     d_instruction_i,
    input  logic [DATA_WIDTH-1:0]     d_pc_i,
    input  logic [DATA_WIDTH-1:0]     d_pc4_i,
    input  logic                      brj_i,
    input  logic                      stall_i,
    output logic                      stall_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic                      e_valid_o,
    output logic [DATA_WIDTH-1:0]     e_pc_o,
    output logic [DATA_WIDTH-1:0]     e_pc4_o,
    output logic [REG_ADDR_WIDTH-1:0] e_rs1_o,
    output logic [REG_ADDR_WIDTH-1:0] e_rs2_o,
    output logic [REG_ADDR_WIDTH-1:0] e_rd_o,
    output logic [DATA_WIDTH-1:0]     e_imm_o,
    output logic [3:0]                e_alu_op_o,
    output logic [1:0]                e_op_a_sel_o,
    output logic                      e_alu_src_o,
    output logic                      e_mem_rd_o,
    output logic                      e_mem_wr_o,
    output logic [2:0]                e_mem_size_o,
    output logic                      e_reg_wr_o,
    output logic                      e_branch_o,
    output logic [1:0]                e_jump_o,
    output logic                      e_illegal_o
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pc4;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     imm;
        logic [3:0]                alu_op;
        logic [1:0]                op_a;
        logic                      alu_src;
        logic                      mem_rd;
        logic                      mem_wr;
        logic [2:0]                mem_size;
        logic                      reg_wr;
        logic                      branch;
        logic [1:0]                jump;
        logic                      illegal;
    } idex_t;

    function automatic logic [3:0] base_alu(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [DATA_WIDTH-1:0] w_ins;
    logic [6:0]            w_opc;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_s;
    logic [DATA_WIDTH-1:0] w_imm_b;
    logic [DATA_WIDTH-1:0] w_imm_u;
    logic [DATA_WIDTH-1:0] w_imm_j;
    logic                  w_bad;
    logic                  w_use1;
    logic                  w_use2;
    logic                  w_hz;
    idex_t                 w_dec;
    idex_t                 r_ex;
    logic                  r_kill_q;

    assign w_ins = d_instruction_i;
    assign w_opc = w_ins[6:0];
    assign w_f3  = w_ins[14:12];
    assign w_f7  = w_ins[31:25];

    assign w_imm_i = {{(DATA_WIDTH-11){w_ins[31]}}, w_ins[30:20]};
    assign w_imm_s = {{(DATA_WIDTH-11){w_ins[31]}}, w_ins[30:25],
                      w_ins[11:7]};
    assign w_imm_b = {{(DATA_WIDTH-12){w_ins[31]}}, w_ins[7],
                      w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_imm_u = {w_ins[DATA_WIDTH-1:12], 12'b0};
    assign w_imm_j = {{(DATA_WIDTH-20){w_ins[31]}}, w_ins[19:12],
                      w_ins[20], w_ins[30:21], 1'b0};

    assign rs1_addr_o = w_ins[15 +: REG_ADDR_WIDTH];
    assign rs2_addr_o = w_ins[20 +: REG_ADDR_WIDTH];

    always_comb begin
        w_dec       = '0;
        w_bad       = 1'b0;
        w_dec.valid = 1'b1;
        w_dec.pc    = d_pc_i;
        w_dec.pc4   = d_pc4_i;
        w_dec.rs1   = w_ins[15 +: REG_ADDR_WIDTH];
        w_dec.rs2   = w_ins[20 +: REG_ADDR_WIDTH];
        w_dec.rd    = w_ins[7 +: REG_ADDR_WIDTH];
        if (w_ins[1:0] != 2'b11) begin
            w_bad = 1'b1;
        end else begin
            case (w_opc)
                OPC_LUI: begin
                    w_dec.op_a    = 2'd2;
                    w_dec.alu_src = 1'b1;
                    w_dec.imm     = w_imm_u;
                    w_dec.reg_wr  = 1'b1;
                end
                OPC_AUIPC: begin
                    w_dec.op_a    = 2'd1;
                    w_dec.alu_src = 1'b1;
                    w_dec.imm     = w_imm_u;
                    w_dec.reg_wr  = 1'b1;
                end
                OPC_JAL: begin
                    w_dec.op_a    = 2'd1;
                    w_dec.alu_src = 1'b1;
                    w_dec.imm     = w_imm_j;
                    w_dec.reg_wr  = 1'b1;
                    w_dec.jump    = 2'd1;
                end
                OPC_JALR: begin
                    w_dec.alu_src = 1'b1;
                    w_dec.imm     = w_imm_i;
                    w_dec.reg_wr  = 1'b1;
                    w_dec.jump    = 2'd2;
                end
                OPC_BR: begin
                    w_dec.alu_op   = ALU_SUB;
                    w_dec.imm      = w_imm_b;
                    w_dec.branch   = 1'b1;
                    w_dec.mem_size = w_f3;
                end
                OPC_LD: begin
                    w_dec.alu_src  = 1'b1;
                    w_dec.imm      = w_imm_i;
                    w_dec.mem_rd   = 1'b1;
                    w_dec.mem_size = w_f3;
                    w_dec.reg_wr   = 1'b1;
                end
                OPC_ST: begin
                    w_dec.alu_src  = 1'b1;
                    w_dec.imm      = w_imm_s;
                    w_dec.mem_wr   = 1'b1;
                    w_dec.mem_size = w_f3;
                end
                OPC_OPI: begin
                    w_dec.alu_src = 1'b1;
                    w_dec.imm     = w_imm_i;
                    w_dec.reg_wr  = 1'b1;
                    w_dec.alu_op  = base_alu(w_f3,
                                    (w_f3 == 3'd5) & w_ins[30]);
                    // Shift-immediates carry funct7 in the upper imm bits
                    if (w_f3 == 3'd1 && w_f7 != 7'h00)
                        w_bad = 1'b1;
                    if (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20)
                        w_bad = 1'b1;
                end
                OPC_OP: begin
                    w_dec.reg_wr = 1'b1;
                    if (w_f7 == 7'h00) begin
                        w_dec.alu_op = base_alu(w_f3, 1'b0);
                    end else if (w_f7 == 7'h20 &&
                                 (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
                        w_dec.alu_op = base_alu(w_f3, 1'b1);
`ifdef RV32M_DECODE_EN
                    end else if (w_f7 == 7'h01) begin
                        if (w_f3[2])
                            w_dec.alu_op = w_f3[1] ? 4'd15 : 4'd14;
                        else
                            w_dec.alu_op = 4'd10 + {2'b00, w_f3[1:0]};
`endif
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                OPC_FENCE: begin
                end
                default: w_bad = 1'b1;
            endcase
        end
        if (w_bad) begin
            w_dec.imm      = '0;
            w_dec.alu_op   = ALU_ADD;
            w_dec.op_a     = 2'd0;
            w_dec.alu_src  = 1'b0;
            w_dec.mem_rd   = 1'b0;
            w_dec.mem_wr   = 1'b0;
            w_dec.mem_size = 3'd0;
            w_dec.reg_wr   = 1'b0;
            w_dec.branch   = 1'b0;
            w_dec.jump     = 2'd0;
            w_dec.illegal  = 1'b1;
        end
        if (w_dec.rd == '0)
            w_dec.reg_wr = 1'b0;
    end

    assign w_use1 = !(w_opc == OPC_LUI || w_opc == OPC_AUIPC ||
                      w_opc == OPC_JAL);
    assign w_use2 = (w_opc == OPC_OP || w_opc == OPC_ST ||
                     w_opc == OPC_BR);

    assign w_hz = r_ex.valid & r_ex.mem_rd & (r_ex.rd != '0) &
                  ((w_use1 & (r_ex.rd == w_dec.rs1)) |
                   (w_use2 & (r_ex.rd == w_dec.rs2)));

    assign stall_o = w_hz & ~brj_i & ~stall_i;

    // kill_q drops the second wrong-path slot behind a taken branch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex     <= '0;
            r_kill_q <= 1'b0;
        end else if (brj_i) begin
            r_ex     <= '0;
            r_kill_q <= 1'b1;
        end else if (!stall_i) begin
            r_kill_q <= 1'b0;
            if (w_hz) begin
                r_ex <= '0;
            end else begin
                r_ex       <= w_dec;
                r_ex.valid <= ~r_kill_q;
            end
        end
    end

    assign e_valid_o    = r_ex.valid;
    assign e_pc_o       = r_ex.pc;
    assign e_pc4_o      = r_ex.pc4;
    assign e_rs1_o      = r_ex.rs1;
    assign e_rs2_o      = r_ex.rs2;
    assign e_rd_o       = r_ex.rd;
    assign e_imm_o      = r_ex.imm;
    assign e_alu_op_o   = r_ex.alu_op;
    assign e_op_a_sel_o = r_ex.op_a;
    assign e_alu_src_o  = r_ex.alu_src;
    assign e_mem_rd_o   = r_ex.mem_rd;
    assign e_mem_wr_o   = r_ex.mem_wr;
    assign e_mem_size_o = r_ex.mem_size;
    assign e_reg_wr_o   = r_ex.reg_wr;
    assign e_branch_o   = r_ex.branch;
    assign e_jump_o     = r_ex.jump;
    assign e_illegal_o  = r_ex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a behavioural decode/pipeline model checked
// every cycle, plus hand-computed expectations for key instructions.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] d_instruction_i;
    logic [31:0] d_pc_i;
    logic [31:0] d_pc4_i;
    logic        brj_i;
    logic        stall_i;
    logic        stall_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic        e_valid_o;
    logic [31:0] e_pc_o;
    logic [31:0] e_pc4_o;
    logic [4:0]  e_rs1_o;
    logic [4:0]  e_rs2_o;
    logic [4:0]  e_rd_o;
    logic [31:0] e_imm_o;
    logic [3:0]  e_alu_op_o;
    logic [1:0]  e_op_a_sel_o;
    logic        e_alu_src_o;
    logic        e_mem_rd_o;
    logic        e_mem_wr_o;
    logic [2:0]  e_mem_size_o;
    logic        e_reg_wr_o;
    logic        e_branch_o;
    logic [1:0]  e_jump_o;
    logic        e_illegal_o;

    id_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .d_instruction_i(d_instruction_i),
        .d_pc_i(d_pc_i), .d_pc4_i(d_pc4_i),
        .brj_i(brj_i), .stall_i(stall_i), .stall_o(stall_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .e_valid_o(e_valid_o), .e_pc_o(e_pc_o), .e_pc4_o(e_pc4_o),
        .e_rs1_o(e_rs1_o), .e_rs2_o(e_rs2_o), .e_rd_o(e_rd_o),
        .e_imm_o(e_imm_o), .e_alu_op_o(e_alu_op_o),
        .e_op_a_sel_o(e_op_a_sel_o), .e_alu_src_o(e_alu_src_o),
        .e_mem_rd_o(e_mem_rd_o), .e_mem_wr_o(e_mem_wr_o),
        .e_mem_size_o(e_mem_size_o), .e_reg_wr_o(e_reg_wr_o),
        .e_branch_o(e_branch_o), .e_jump_o(e_jump_o),
        .e_illegal_o(e_illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RV32M_DECODE_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  op_a;
        logic        src;
        logic        mrd;
        logic        mwr;
        logic [2:0]  msz;
        logic        rwr;
        logic        br;
        logic [1:0]  jmp;
        logic        ill;
    } exp_t;

    localparam logic [3:0] ALU_T [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    localparam logic [3:0] MUL_T [8] = '{10, 11, 12, 13, 14, 14, 15, 15};

    int    errors = 0;
    int    checks = 0;
    int    stalls = 0;
    exp_t  m;
    logic  m_kill;
    logic [31:0] pc;
    logic  st;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic exp_t model_dec(input logic [31:0] x,
                                       input logic [31:0] p);
        exp_t e;
        exp_t k;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        op = x[6:0];
        f3 = x[14:12];
        f7 = x[31:25];
        ok = 1'b1;
        e = '0;
        e.valid = 1'b1;
        e.pc = p;
        e.pc4 = p + 32'd4;
        e.rs1 = x[19:15];
        e.rs2 = x[24:20];
        e.rd = x[11:7];
        case (op)
            7'h37: begin
                e.op_a = 2; e.src = 1; e.rwr = 1;
                e.imm = {x[31:12], 12'b0};
            end
            7'h17: begin
                e.op_a = 1; e.src = 1; e.rwr = 1;
                e.imm = {x[31:12], 12'b0};
            end
            7'h6F: begin
                e.op_a = 1; e.src = 1; e.rwr = 1; e.jmp = 1;
                e.imm = {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
            end
            7'h67: begin
                e.src = 1; e.rwr = 1; e.jmp = 2;
                e.imm = {{21{x[31]}}, x[30:20]};
            end
            7'h63: begin
                e.alu = 1; e.br = 1; e.msz = f3;
                e.imm = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
            end
            7'h03: begin
                e.src = 1; e.mrd = 1; e.msz = f3; e.rwr = 1;
                e.imm = {{21{x[31]}}, x[30:20]};
            end
            7'h23: begin
                e.src = 1; e.mwr = 1; e.msz = f3;
                e.imm = {{21{x[31]}}, x[30:25], x[11:7]};
            end
            7'h13: begin
                e.src = 1; e.rwr = 1;
                e.imm = {{21{x[31]}}, x[30:20]};
                e.alu = ALU_T[f3];
                if (f3 == 5 && x[30]) e.alu = 7;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                e.rwr = 1;
                if (f7 == 0) e.alu = ALU_T[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = 1;
                else if (f7 == 7'h20 && f3 == 5) e.alu = 7;
                else if (MEXT && f7 == 1) e.alu = MUL_T[f3];
                else ok = 1'b0;
            end
            7'h0F: ;
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            k = e;
            e = '0;
            e.valid = 1'b1;
            e.pc = k.pc;
            e.pc4 = k.pc4;
            e.rs1 = k.rs1;
            e.rs2 = k.rs2;
            e.rd = k.rd;
            e.ill = 1'b1;
        end
        if (e.rd == 0) e.rwr = 1'b0;
        return e;
    endfunction

    function automatic logic reads1(input logic [31:0] x);
        return !(x[6:0] == 7'h37 || x[6:0] == 7'h17 || x[6:0] == 7'h6F);
    endfunction

    function automatic logic reads2(input logic [31:0] x);
        return x[6:0] == 7'h33 || x[6:0] == 7'h23 || x[6:0] == 7'h63;
    endfunction

    task automatic cmp_all(input logic [31:0] x, input logic est);
        chk("stall_o", stall_o, est);
        chk("rs1_addr", rs1_addr_o, x[19:15]);
        chk("rs2_addr", rs2_addr_o, x[24:20]);
        chk("valid", e_valid_o, m.valid);
        chk("pc", e_pc_o, m.pc);
        chk("pc4", e_pc4_o, m.pc4);
        chk("rs1", e_rs1_o, m.rs1);
        chk("rs2", e_rs2_o, m.rs2);
        chk("rd", e_rd_o, m.rd);
        chk("imm", e_imm_o, m.imm);
        chk("alu_op", e_alu_op_o, m.alu);
        chk("op_a", e_op_a_sel_o, m.op_a);
        chk("alu_src", e_alu_src_o, m.src);
        chk("mem_rd", e_mem_rd_o, m.mrd);
        chk("mem_wr", e_mem_wr_o, m.mwr);
        chk("mem_size", e_mem_size_o, m.msz);
        chk("reg_wr", e_reg_wr_o, m.rwr);
        chk("branch", e_branch_o, m.br);
        chk("jump", e_jump_o, m.jmp);
        chk("illegal", e_illegal_o, m.ill);
    endtask

    // One clock: drive, compare at negedge, advance model at posedge.
    task automatic cycle(input logic [31:0] x, input logic b,
                         input logic s, output logic so);
        logic haz;
        exp_t nxt;
        d_instruction_i = x;
        d_pc_i = pc;
        d_pc4_i = pc + 32'd4;
        brj_i = b;
        stall_i = s;
        @(negedge clk);
        haz = m.valid && m.mrd && m.rd != 0 &&
              ((reads1(x) && m.rd == x[19:15]) ||
               (reads2(x) && m.rd == x[24:20]));
        so = haz && !b && !s;
        cmp_all(x, so);
        nxt = m;
        if (b) begin
            nxt = '0;
            m_kill = 1'b1;
        end else if (!s) begin
            if (haz) nxt = '0;
            else begin
                nxt = model_dec(x, pc);
                nxt.valid = !m_kill;
            end
            m_kill = 1'b0;
        end
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic issue(input logic [31:0] x);
        int n;
        logic so;
        n = 0;
        do begin
            cycle(x, 1'b0, 1'b0, so);
            if (so) stalls++;
            n++;
        end while (so && n < 4);
        chk("fetch_bound", so, 1'b0);
        pc = pc + 32'd4;
    endtask

    initial begin
        rst = 1'b1;
        d_instruction_i = '0;
        d_pc_i = '0;
        d_pc4_i = '0;
        brj_i = 1'b0;
        stall_i = 1'b0;
        m = '0;
        m_kill = 1'b0;
        pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        cmp_all(32'h0, 1'b0);
        chk("rst_valid", e_valid_o, 1'b0);
        rst = 1'b0;

        issue(32'h00500093);
        chk("addi_valid", e_valid_o, 1'b1);
        chk("addi_rd", e_rd_o, 5'd1);
        chk("addi_imm", e_imm_o, 32'd5);
        chk("addi_alu", e_alu_op_o, 4'd0);
        chk("addi_src", e_alu_src_o, 1'b1);
        chk("addi_rwr", e_reg_wr_o, 1'b1);

        stalls = 0;
        issue(32'h0000A103);
        issue(32'h001101B3);
        chk("lu_stalls", stalls, 1);
        chk("lu_valid", e_valid_o, 1'b1);
        chk("lu_rs1", e_rs1_o, 5'd2);
        chk("lu_rs2", e_rs2_o, 5'd1);

        stalls = 0;
        issue(32'h0000A003);
        issue(32'h001001B3);
        chk("x0_stalls", stalls, 0);

        stalls = 0;
        issue(32'h0000A283);
        issue(32'h00532423);
        chk("st_rs2_stalls", stalls, 1);
        stalls = 0;
        issue(32'h0000A303);
        issue(32'h12345337);
        chk("lui_stalls", stalls, 0);

        issue(32'h0000A103);
        cycle(32'h001101B3, 1'b1, 1'b0, st);
        chk("brj_nostall", st, 1'b0);
        chk("brj_v1", e_valid_o, 1'b0);
        pc = pc + 32'd4;
        issue(32'h00300193);
        chk("brj_v2", e_valid_o, 1'b0);
        issue(32'h00400213);
        chk("brj_v3", e_valid_o, 1'b1);
        issue(32'h00500293);
        chk("brj_v4", e_valid_o, 1'b1);

        issue(32'h00532423);
        for (int i = 0; i < 3; i++) begin
            cycle(32'h00000013, 1'b0, 1'b1, st);
            chk("hold_mwr", e_mem_wr_o, 1'b1);
            chk("hold_imm", e_imm_o, 32'd8);
            chk("hold_valid", e_valid_o, 1'b1);
        end
        issue(32'h00000013);
        chk("nop_rwr", e_reg_wr_o, 1'b0);
        chk("nop_alu", e_alu_op_o, 4'd0);

        issue(32'h0000A103);
        cycle(32'h001101B3, 1'b0, 1'b1, st);
        chk("stl_nostall", st, 1'b0);
        stalls = 0;
        issue(32'h001101B3);
        chk("stl_stalls", stalls, 1);

        issue(32'h123452B7);
        chk("lui_imm", e_imm_o, 32'h12345000);
        chk("lui_opa", e_op_a_sel_o, 2'd2);
        issue(32'h008000EF);
        chk("jal_jump", e_jump_o, 2'd1);
        chk("jal_imm", e_imm_o, 32'd8);
        issue(32'hFE208CE3);
        chk("beq_imm", e_imm_o, 32'hFFFFFFF8);
        chk("beq_br", e_branch_o, 1'b1);
        chk("beq_alu", e_alu_op_o, 4'd1);
        issue(32'h403100B3);
        chk("sub_alu", e_alu_op_o, 4'd1);
        issue(32'h4030D093);
        chk("srai_alu", e_alu_op_o, 4'd7);
        issue(32'h0000000F);
        chk("fence_ill", e_illegal_o, 1'b0);
        chk("fence_v", e_valid_o, 1'b1);
        issue(32'h00000000);
        chk("zero_ill", e_illegal_o, 1'b1);
        issue(32'h80000033);
        chk("f7_ill", e_illegal_o, 1'b1);
        chk("f7_rwr", e_reg_wr_o, 1'b0);
        issue(32'h00001097);
        issue(32'h000080E7);
        issue(32'h00209183);
        issue(32'h00520023);
        issue(32'h0020E1B3);
        issue(32'hFFF0A213);
        issue(32'h8001D093);
        issue(32'h00000073);

        issue(32'h02208033);
`ifdef RV32M_DECODE_EN
        chk("mul_alu", e_alu_op_o, 4'd10);
        chk("mul_ill", e_illegal_o, 1'b0);
`else
        chk("mul_ill", e_illegal_o, 1'b1);
`endif
        issue(32'h0220C1B3);
        issue(32'h0220F1B3);
        issue(32'h00000013);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
